// File: rtl/fir_post_decim_pkg.sv
// Shared definitions for the FIR core and its post-decimation output stage.
package fir_post_decim_pkg;

    localparam int FIR_OUT_W       = 29;
    localparam int POST_OUT_W      = 16;
    localparam int POST_SHIFT      = 8;
    localparam int POST_DEC        = 4;
    localparam int POST_FIFO_DEPTH = 8;
    localparam int POST_FIFO_AW    = 3;

    // Phase counter width covers DEC up to 256.
    localparam int PH_W = 8;

endpackage

// File: rtl/fir_post_decim_sfifo.sv
// Show-ahead synchronous FIFO with level output; a write on a full FIFO is
// accepted only when a read happens in the same cycle.
module fir_sfifo
    import fir_post_decim_pkg::*;
#(
    parameter int WIDTH = POST_OUT_W,
    parameter int DEPTH = POST_FIFO_DEPTH,
    parameter int AW    = POST_FIFO_AW
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_rdata,
    output logic [AW:0]      o_level,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_rd;
    logic             w_wr;

    assign o_level = r_wr_ptr - r_rd_ptr;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (o_level == (AW+1)'(DEPTH));
    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

    assign w_rd = i_rd & ~o_empty;
    // When full, the slot being written is the one leaving through the read port.
    assign w_wr = i_wr & (~o_full | w_rd);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
                r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/fir_post_decim.sv
// Output stage after the parallel FIR: keeps one sample in DEC, rounds/saturates
// it to OUT_W bits and buffers it in a show-ahead FIFO with valid/ready drain.
module fir_post_decim
    import fir_post_decim_pkg::*;
#(
    parameter int IN_W       = FIR_OUT_W,
    parameter int OUT_W      = POST_OUT_W,
    parameter int SHIFT      = POST_SHIFT,
    parameter int DEC        = POST_DEC,
    parameter int FIFO_DEPTH = POST_FIFO_DEPTH,
    parameter int AW         = POST_FIFO_AW
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             din_valid,
    input  logic [IN_W-1:0]  din,
    input  logic             phase_clr,
    input  logic             clr_flags,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [OUT_W-1:0] dout,
    output logic [AW:0]      fifo_level,
    output logic             ovf_sticky,
    output logic             sat_sticky
);

    // Round-half-up at IN_W+1 bits, then clamp; MSB of the result flags saturation.
    function automatic logic [OUT_W:0] round_sat(input logic [IN_W-1:0] d);
        logic [IN_W:0] sum;
        logic [IN_W:0] q;
        sum = {1'b0, d} + ((IN_W+1)'(1) << (SHIFT - 1));
        q   = sum >> SHIFT;
        if (q > (IN_W+1)'({OUT_W{1'b1}}))
            return {1'b1, {OUT_W{1'b1}}};
        return {1'b0, q[OUT_W-1:0]};
    endfunction

    logic [PH_W-1:0]  r_ph;
    logic [PH_W-1:0]  w_ph_start;
    logic             w_keep;
    logic [OUT_W:0]   w_rs_p0;
    logic             r_vld_p1;
    logic [OUT_W-1:0] r_round_p1;
    logic             w_full;
    logic             w_empty;
    logic             w_sat_set;
    logic             w_ovf_set;

    assign w_ph_start = phase_clr ? '0 : r_ph;
    assign w_keep     = din_valid & (w_ph_start == '0);
    assign w_rs_p0    = round_sat(din);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ph <= '0;
        end else if (din_valid) begin
            r_ph <= (w_ph_start == PH_W'(DEC - 1)) ? '0 : w_ph_start + PH_W'(1);
        end else if (phase_clr) begin
            r_ph <= '0;
        end
    end

    // ---- stage p0 -> p1: rounded/saturated kept sample ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vld_p1   <= 1'b0;
            r_round_p1 <= '0;
        end else begin
            r_vld_p1 <= w_keep;
            if (w_keep) begin
                r_round_p1 <= w_rs_p0[OUT_W-1:0];
            end
        end
    end

    // ---- stage p1 -> FIFO ----
    fir_sfifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_wr    (r_vld_p1),
        .i_wdata (r_round_p1),
        .i_rd    (dout_ready),
        .o_rdata (dout),
        .o_level (fifo_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign dout_valid = ~w_empty;

    assign w_sat_set = w_keep & w_rs_p0[OUT_W];
    // A full FIFO is never empty, so dout_ready alone decides whether a read frees a slot.
    assign w_ovf_set = r_vld_p1 & w_full & ~dout_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sat_sticky <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            if (w_sat_set)
                sat_sticky <= 1'b1;
            else if (clr_flags)
                sat_sticky <= 1'b0;
            if (w_ovf_set)
                ovf_sticky <= 1'b1;
            else if (clr_flags)
                ovf_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_post_decim.sv
// Directed bench for fir_post_decim: default instance (DEC=4) plus a DEC=1 instance.
module tb_fir_post_decim;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic        a_dv, a_pc, a_cf, a_rdy, a_ov, a_ovf, a_sat;
    logic [28:0] a_din;
    logic [15:0] a_dout;
    logic [3:0]  a_lvl;

    logic        b_dv, b_pc, b_cf, b_rdy, b_ov, b_ovf, b_sat;
    logic [28:0] b_din;
    logic [15:0] b_dout;
    logic [3:0]  b_lvl;

    fir_post_decim u_a (
        .clk(clk), .rstn(rstn), .din_valid(a_dv), .din(a_din), .phase_clr(a_pc),
        .clr_flags(a_cf), .dout_valid(a_ov), .dout_ready(a_rdy), .dout(a_dout),
        .fifo_level(a_lvl), .ovf_sticky(a_ovf), .sat_sticky(a_sat)
    );

    fir_post_decim #(.DEC(1)) u_b (
        .clk(clk), .rstn(rstn), .din_valid(b_dv), .din(b_din), .phase_clr(b_pc),
        .clr_flags(b_cf), .dout_valid(b_ov), .dout_ready(b_rdy), .dout(b_dout),
        .fifo_level(b_lvl), .ovf_sticky(b_ovf), .sat_sticky(b_sat)
    );

    int checks = 0;
    int errors = 0;
    int seen   = 0;
    int expq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle on instance A; every presented head is checked against expq.
    task automatic cyc(input string tag, input logic dv, input logic [28:0] d, input logic pc);
        logic [31:0] e;
        a_dv  = dv;
        a_din = d;
        a_pc  = pc;
        tick();
        a_pc = 1'b0;
        if (a_ov) begin
            e = (expq.size() > 0) ? 32'(expq.pop_front()) : 32'hFFFF_FFFF;
            chk(tag, 32'(a_dout), e);
            seen++;
        end
    endtask

    initial begin
        int bv[5];
        int be[5];
        {a_dv, a_pc, a_cf, a_rdy} = '0;
        {b_dv, b_pc, b_cf, b_rdy} = '0;
        a_din = '0;
        b_din = '0;
        tick();
        tick();
        chk("rst_valid", 32'(a_ov), 0);
        chk("rst_dout",  32'(a_dout), 0);
        chk("rst_level", 32'(a_lvl), 0);
        chk("rst_ovf",   32'(a_ovf), 0);
        chk("rst_sat",   32'(a_sat), 0);
        rstn = 1'b1;
        tick();

        // 1: DEC=4, din=256*k every cycle
        a_rdy = 1'b1;
        for (int k = 0; k < 16; k++) begin
            a_dv  = 1'b1;
            a_din = 29'(256 * k);
            tick();
            if (k >= 1 && ((k - 1) % 4) == 0) begin
                chk("t1_valid", 32'(a_ov), 1);
                chk("t1_dout", 32'(a_dout), 32'(k - 1));
            end else begin
                chk("t1_valid", 32'(a_ov), 0);
            end
        end
        a_dv = 1'b0;
        tick();
        chk("t1_tail_valid", 32'(a_ov), 0);

        // 2: DEC=1 rounding and saturation
        bv = '{383, 384, 128, 127, 32'h1FFF_FFFF};
        be = '{1, 2, 1, 0, 32'hFFFF};
        b_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b_dv  = 1'b1;
            b_din = 29'(bv[i]);
            tick();
            chk("t2_sat", 32'(b_sat), (i == 4) ? 1 : 0);
            if (i >= 1) chk("t2_dout", 32'(b_dout), 32'(be[i - 1]));
        end
        b_dv = 1'b0;
        tick();
        chk("t2_dout_sat", 32'(b_dout), 32'hFFFF);
        tick();
        chk("t2_drained", 32'(b_ov), 0);
        b_cf = 1'b1;
        tick();
        b_cf = 1'b0;
        chk("t2_sat_clr", 32'(b_sat), 0);
        b_cf  = 1'b1;
        b_dv  = 1'b1;
        b_din = 29'h1FFF_FFFF;
        tick();
        {b_cf, b_dv} = '0;
        chk("t2_set_wins", 32'(b_sat), 1);
        b_cf = 1'b1;
        tick();
        b_cf = 1'b0;
        chk("t2_sat_clr2", 32'(b_sat), 0);

        // 3: overflow with consumer stalled
        a_rdy = 1'b0;
        for (int k = 0; k < 40; k++) begin
            a_dv  = 1'b1;
            a_din = (k % 4 == 0) ? 29'((1000 + k / 4) * 256) : 29'h0ABCDEF;
            tick();
        end
        a_dv = 1'b0;
        tick();
        tick();
        chk("t3_level", 32'(a_lvl), 8);
        chk("t3_ovf", 32'(a_ovf), 1);
        a_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t3_valid", 32'(a_ov), 1);
            chk("t3_dout", 32'(a_dout), 32'(1000 + i));
            tick();
        end
        chk("t3_empty", 32'(a_ov), 0);
        chk("t3_level0", 32'(a_lvl), 0);
        a_rdy = 1'b0;

        // 4: write and read together on a full FIFO
        a_cf = 1'b1;
        tick();
        a_cf = 1'b0;
        chk("t4_ovf_clr", 32'(a_ovf), 0);
        for (int k = 0; k < 32; k++) begin
            a_dv  = 1'b1;
            a_din = (k % 4 == 0) ? 29'((2000 + k / 4) * 256) : 29'h0012345;
            tick();
        end
        a_dv = 1'b0;
        tick();
        tick();
        chk("t4_full", 32'(a_lvl), 8);
        a_dv  = 1'b1;
        a_din = 29'(2008 * 256);
        tick();
        a_dv  = 1'b0;
        a_rdy = 1'b1;
        tick();
        a_rdy = 1'b0;
        chk("t4_level", 32'(a_lvl), 8);
        chk("t4_ovf", 32'(a_ovf), 0);
        tick();
        chk("t4_head_stable", 32'(a_dout), 2001);
        a_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t4_dout", 32'(a_dout), 32'(2001 + i));
            tick();
        end
        chk("t4_empty", 32'(a_ov), 0);

        // 5: phase_clr alone and together with din_valid
        expq = '{100, 102, 106, 108, 112};
        seen = 0;
        cyc("t5_dout", 1'b0, '0, 1'b1);
        cyc("t5_dout", 1'b1, 29'(100 * 256), 1'b0);
        cyc("t5_dout", 1'b1, 29'(101 * 256), 1'b0);
        cyc("t5_dout", 1'b0, '0, 1'b1);
        for (int k = 2; k < 13; k++) begin
            cyc("t5_dout", 1'b1, 29'((100 + k) * 256), (k == 8) ? 1'b1 : 1'b0);
        end
        for (int i = 0; i < 3; i++) cyc("t5_dout", 1'b0, '0, 1'b0);
        chk("t5_count", 32'(seen), 5);

        // 6: asynchronous reset with five entries held
        a_rdy = 1'b0;
        cyc("t6_fill", 1'b0, '0, 1'b1);
        for (int k = 0; k < 17; k++) begin
            a_dv  = 1'b1;
            a_din = (k == 16) ? 29'h1FFF_FFFF : 29'((400 + k) * 256);
            tick();
        end
        a_dv = 1'b0;
        tick();
        tick();
        chk("t6_level5", 32'(a_lvl), 5);
        chk("t6_sat_pre", 32'(a_sat), 1);
        #3;
        rstn = 1'b0;
        #1;
        chk("t6_valid", 32'(a_ov), 0);
        chk("t6_level", 32'(a_lvl), 0);
        chk("t6_sat", 32'(a_sat), 0);
        chk("t6_ovf", 32'(a_ovf), 0);
        chk("t6_dout", 32'(a_dout), 0);
        #2;
        rstn = 1'b1;
        tick();
        a_rdy = 1'b1;
        expq = '{300, 304};
        seen = 0;
        for (int k = 0; k < 8; k++) cyc("t6_post", 1'b1, 29'((300 + k) * 256), 1'b0);
        for (int i = 0; i < 3; i++) cyc("t6_post", 1'b0, '0, 1'b0);
        chk("t6_count", 32'(seen), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
